pipe_ctrl_regs: RTL and testbench

//  Pipeline register bank for the 5-stage ARM core: PC (F), instruction (F->D), control/address (D->E->M->W).

---
 rtl/pipe_ctrl_regs.sv | 190 +++++++++++++++++++
 tb/tb_pipe_ctrl_regs.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_regs.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_regs
//  Description : Pipeline register bank for the 5-stage ARM core. Holds the
//                fetch PC, the F->D instruction register and the control /
//                address fields carried D->E->M->W. Applies the hazard unit's
//                stall and flush requests and gates stores, register writes
//                and PC writes with the E-stage condition result at E->M.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_regs #(
    parameter int              AW     = 4,
    parameter int              DW     = 32,
    parameter logic [DW-1:0]   PC_RST = '0
) (
    input  logic          clk,
    input  logic          reset,
    // hazard unit requests
    input  logic          StallF,
    input  logic          StallD,
    input  logic          FlushD,
    input  logic          FlushE,
    // fetch
    input  logic [DW-1:0] PCNextF,
    input  logic [DW-1:0] InstrF,
    output logic [DW-1:0] PCF,
    // decode
    output logic [DW-1:0] InstrD,
    output logic          ValidD,
    input  logic          RegWriteD,
    input  logic          MemtoRegD,
    input  logic          MemWriteD,
    input  logic          BranchD,
    input  logic          PCSrcD,
    input  logic [AW-1:0] RA1D,
    input  logic [AW-1:0] RA2D,
    input  logic [AW-1:0] WA3D,
    // execute
    input  logic          CondExE,
    output logic [AW-1:0] RA1E,
    output logic [AW-1:0] RA2E,
    output logic [AW-1:0] WA3E,
    output logic          MemtoRegE,
    output logic          PCSrcE,
    output logic          BranchTakenE,
    // memory
    output logic          RegWriteM,
    output logic          MemtoRegM,
    output logic          MemWriteM,
    output logic          PCSrcM,
    output logic [AW-1:0] WA3M,
    // writeback
    output logic          RegWriteW,
    output logic          MemtoRegW,
    output logic          PCSrcW,
    output logic [AW-1:0] WA3W
);

    // ------------------------------------------------------------------
    // Stage state
    // ------------------------------------------------------------------
    logic [DW-1:0] r_pc_f;

    logic [DW-1:0] r_instr_d;
    logic          r_valid_d;

    logic          r_reg_write_e;
    logic          r_memto_reg_e;
    logic          r_mem_write_e;
    logic          r_branch_e;
    logic          r_pc_src_e;
    logic [AW-1:0] r_ra1_e;
    logic [AW-1:0] r_ra2_e;
    logic [AW-1:0] r_wa3_e;

    logic          r_reg_write_m;
    logic          r_memto_reg_m;
    logic          r_mem_write_m;
    logic          r_pc_src_m;
    logic [AW-1:0] r_wa3_m;

    logic          r_reg_write_w;
    logic          r_memto_reg_w;
    logic          r_pc_src_w;
    logic [AW-1:0] r_wa3_w;

    // Fetch PC: hold on stall, otherwise take the next PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_f <= PC_RST;
        end else if (!StallF) begin
            r_pc_f <= PCNextF;
        end
    end

    // Decode register: flush beats stall so a squashed slot never survives.
    always_ff @(posedge clk) begin
        if (reset || FlushD) begin
            r_instr_d <= '0;
            r_valid_d <= 1'b0;
        end else if (!StallD) begin
            r_instr_d <= InstrF;
            r_valid_d <= 1'b1;
        end
    end

    // Execute register: bubble on flush; an invalid D slot loads as a bubble.
    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            r_reg_write_e <= 1'b0;
            r_memto_reg_e <= 1'b0;
            r_mem_write_e <= 1'b0;
            r_branch_e    <= 1'b0;
            r_pc_src_e    <= 1'b0;
            r_ra1_e       <= '0;
            r_ra2_e       <= '0;
            r_wa3_e       <= '0;
        end else begin
            r_reg_write_e <= RegWriteD & r_valid_d;
            r_memto_reg_e <= MemtoRegD & r_valid_d;
            r_mem_write_e <= MemWriteD & r_valid_d;
            r_branch_e    <= BranchD   & r_valid_d;
            r_pc_src_e    <= PCSrcD    & r_valid_d;
            r_ra1_e       <= RA1D;
            r_ra2_e       <= RA2D;
            r_wa3_e       <= WA3D;
        end
    end

    // Memory register: architectural side effects are dropped when the
    // condition check in E failed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_write_m <= 1'b0;
            r_memto_reg_m <= 1'b0;
            r_mem_write_m <= 1'b0;
            r_pc_src_m    <= 1'b0;
            r_wa3_m       <= '0;
        end else begin
            r_reg_write_m <= r_reg_write_e & CondExE;
            r_memto_reg_m <= r_memto_reg_e;
            r_mem_write_m <= r_mem_write_e & CondExE;
            r_pc_src_m    <= r_pc_src_e    & CondExE;
            r_wa3_m       <= r_wa3_e;
        end
    end

    // Writeback register: straight copy of the memory stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_write_w <= 1'b0;
            r_memto_reg_w <= 1'b0;
            r_pc_src_w    <= 1'b0;
            r_wa3_w       <= '0;
        end else begin
            r_reg_write_w <= r_reg_write_m;
            r_memto_reg_w <= r_memto_reg_m;
            r_pc_src_w    <= r_pc_src_m;
            r_wa3_w       <= r_wa3_m;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign PCF          = r_pc_f;
    assign InstrD       = r_instr_d;
    assign ValidD       = r_valid_d;

    assign RA1E         = r_ra1_e;
    assign RA2E         = r_ra2_e;
    assign WA3E         = r_wa3_e;
    assign MemtoRegE    = r_memto_reg_e;
    assign PCSrcE       = r_pc_src_e;
    // Unregistered so the fetch redirect happens in the same cycle.
    assign BranchTakenE = r_branch_e & CondExE;

    assign RegWriteM    = r_reg_write_m;
    assign MemtoRegM    = r_memto_reg_m;
    assign MemWriteM    = r_mem_write_m;
    assign PCSrcM       = r_pc_src_m;
    assign WA3M         = r_wa3_m;

    assign RegWriteW    = r_reg_write_w;
    assign MemtoRegW    = r_memto_reg_w;
    assign PCSrcW       = r_pc_src_w;
    assign WA3W         = r_wa3_w;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl_regs
//  Description : Scoreboard bench for pipe_ctrl_regs. A predictor turns each
//                cycle's stimulus into the expected post-edge pipeline
//                contents and queues it; a monitor pops one entry after every
//                rising edge and compares it with the DUT outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl_regs;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam logic [DW-1:0] C_PC_RST = '0;

    logic          clk = 1'b0;
    logic          reset;
    logic          StallF, StallD, FlushD, FlushE;
    logic [DW-1:0] PCNextF, InstrF;
    logic [DW-1:0] PCF, InstrD;
    logic          ValidD;
    logic          RegWriteD, MemtoRegD, MemWriteD, BranchD, PCSrcD;
    logic [AW-1:0] RA1D, RA2D, WA3D;
    logic          CondExE;
    logic [AW-1:0] RA1E, RA2E, WA3E;
    logic          MemtoRegE, PCSrcE, BranchTakenE;
    logic          RegWriteM, MemtoRegM, MemWriteM, PCSrcM;
    logic [AW-1:0] WA3M;
    logic          RegWriteW, MemtoRegW, PCSrcW;
    logic [AW-1:0] WA3W;

    pipe_ctrl_regs #(.AW(AW), .DW(DW), .PC_RST(C_PC_RST)) dut (
        .clk(clk), .reset(reset),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .PCNextF(PCNextF), .InstrF(InstrF), .PCF(PCF),
        .InstrD(InstrD), .ValidD(ValidD),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
        .BranchD(BranchD), .PCSrcD(PCSrcD),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .CondExE(CondExE),
        .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E),
        .MemtoRegE(MemtoRegE), .PCSrcE(PCSrcE), .BranchTakenE(BranchTakenE),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .PCSrcM(PCSrcM), .WA3M(WA3M),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW),
        .WA3W(WA3W)
    );

    always #5 clk = ~clk;

    // One in-flight instruction's control/address record; all-zero is a bubble.
    typedef struct packed {
        logic       rw, mtr, mw, br, pcs;
        logic [3:0] ra1, ra2, wa3;
    } ctl_t;

    // Whole-pipeline view expected just after an edge.
    typedef struct packed {
        logic [31:0] pc, instr;
        logic        valid;
        ctl_t        e, m, w;
        logic        cond;
    } snap_t;

    snap_t mdl;
    snap_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Predict the pipeline after the coming edge from the inputs now driven.
    task automatic predict();
        snap_t n;
        ctl_t  dec;
        n = mdl;
        if (reset) begin
            n = '0;
            n.pc = C_PC_RST;
        end else begin
            if (!StallF) n.pc = PCNextF;
            if (FlushD) begin
                n.instr = '0;
                n.valid = 1'b0;
            end else if (!StallD) begin
                n.instr = InstrF;
                n.valid = 1'b1;
            end
            // what the decoder says, suppressed entirely if D is empty
            dec = '{rw: RegWriteD, mtr: MemtoRegD, mw: MemWriteD, br: BranchD,
                    pcs: PCSrcD, ra1: RA1D, ra2: RA2D, wa3: WA3D};
            if (!mdl.valid) begin
                dec.rw = 0; dec.mtr = 0; dec.mw = 0; dec.br = 0; dec.pcs = 0;
            end
            n.e = FlushE ? ctl_t'(0) : dec;
            // an instruction whose condition failed keeps only harmless fields
            n.m = mdl.e;
            if (!CondExE) begin
                n.m.rw = 0; n.m.mw = 0; n.m.pcs = 0;
            end
            n.w = mdl.m;
        end
        n.cond = CondExE;
        mdl = n;
        sb.push_back(n);
    endtask

    task automatic cycle();
        predict();
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 0; StallF = 0; StallD = 0; FlushD = 0; FlushE = 0;
        PCNextF = '0; InstrF = '0;
        RegWriteD = 0; MemtoRegD = 0; MemWriteD = 0; BranchD = 0; PCSrcD = 0;
        RA1D = '0; RA2D = '0; WA3D = '0; CondExE = 1;
    endtask

    task automatic rand_inputs();
        int r;
        idle();
        reset = ($urandom_range(0, 99) < 2);
        r = $urandom_range(0, 9);
        if (r < 2) begin
            StallF = 1; StallD = 1; FlushE = 1;
        end else begin
            StallF = ($urandom_range(0, 9) == 0);
            StallD = ($urandom_range(0, 9) == 0);
            FlushE = ($urandom_range(0, 9) == 0);
        end
        FlushD    = ($urandom_range(0, 9) == 0);
        PCNextF   = $urandom;
        InstrF    = $urandom;
        RegWriteD = $urandom_range(0, 1);
        MemtoRegD = $urandom_range(0, 1);
        MemWriteD = $urandom_range(0, 1);
        BranchD   = $urandom_range(0, 1);
        PCSrcD    = $urandom_range(0, 1);
        RA1D      = 4'($urandom);
        RA2D      = 4'($urandom);
        WA3D      = 4'($urandom);
        CondExE   = $urandom_range(0, 1);
    endtask

    // Monitor: one expected snapshot per rising edge.
    initial begin
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("PCF",          PCF,          e.pc);
                chk("InstrD",       InstrD,       e.instr);
                chk("ValidD",       32'(ValidD),  32'(e.valid));
                chk("RA1E",         32'(RA1E),    32'(e.e.ra1));
                chk("RA2E",         32'(RA2E),    32'(e.e.ra2));
                chk("WA3E",         32'(WA3E),    32'(e.e.wa3));
                chk("MemtoRegE",    32'(MemtoRegE), 32'(e.e.mtr));
                chk("PCSrcE",       32'(PCSrcE),  32'(e.e.pcs));
                chk("BranchTakenE", 32'(BranchTakenE), 32'(e.e.br & e.cond));
                chk("RegWriteM",    32'(RegWriteM), 32'(e.m.rw));
                chk("MemtoRegM",    32'(MemtoRegM), 32'(e.m.mtr));
                chk("MemWriteM",    32'(MemWriteM), 32'(e.m.mw));
                chk("PCSrcM",       32'(PCSrcM),  32'(e.m.pcs));
                chk("WA3M",         32'(WA3M),    32'(e.m.wa3));
                chk("RegWriteW",    32'(RegWriteW), 32'(e.w.rw));
                chk("MemtoRegW",    32'(MemtoRegW), 32'(e.w.mtr));
                chk("PCSrcW",       32'(PCSrcW),  32'(e.w.pcs));
                chk("WA3W",         32'(WA3W),    32'(e.w.wa3));
            end
        end
    end

    // Stimulus
    initial begin
        mdl = '0;
        idle();
        reset = 1;
        cycle();
        cycle();

        // straight pipe: write to r5, condition passes all the way
        idle(); PCNextF = 32'h4; InstrF = 32'hE3A05001; cycle();
        idle(); RegWriteD = 1; WA3D = 4'd5; RA1D = 4'd1; RA2D = 4'd2; cycle();
        idle(); cycle();
        idle(); cycle();

        // condition fail on a PC-writing instruction
        idle(); InstrF = 32'hE1A0F00E; cycle();
        idle(); RegWriteD = 1; PCSrcD = 1; WA3D = 4'd15; cycle();
        idle(); CondExE = 0; cycle();
        idle(); cycle();

        // load-use stall with a load sitting in D
        idle(); PCNextF = 32'h10; InstrF = 32'hE5912000; MemtoRegD = 1; WA3D = 4'd2; cycle();
        idle(); PCNextF = 32'h14; MemtoRegD = 1; RegWriteD = 1; WA3D = 4'd2; RA1D = 4'd1; cycle();
        idle(); StallF = 1; StallD = 1; FlushE = 1; PCNextF = 32'h18; RegWriteD = 1; WA3D = 4'd3; cycle();
        idle(); cycle();

        // flush beats stall; the emptied slot must load as a bubble
        idle(); InstrF = 32'hE0811002; cycle();
        idle(); FlushD = 1; StallD = 1; RegWriteD = 1; WA3D = 4'd7; cycle();
        idle(); RegWriteD = 1; MemWriteD = 1; PCSrcD = 1; WA3D = 4'd7; cycle();
        idle(); cycle();

        // branch taken / not taken
        idle(); InstrF = 32'hEA000004; cycle();
        idle(); BranchD = 1; InstrF = 32'h0A000004; cycle();
        idle(); BranchD = 1; CondExE = 1; cycle();
        idle(); CondExE = 0; cycle();

        // reset with every stage full
        idle(); InstrF = 32'h12345678; RegWriteD = 1; PCSrcD = 1; WA3D = 4'd9; cycle();
        idle(); InstrF = 32'h9ABCDEF0; RegWriteD = 1; PCSrcD = 1; WA3D = 4'd9; cycle();
        idle(); RegWriteD = 1; PCSrcD = 1; WA3D = 4'd9; cycle();
        idle(); reset = 1; RegWriteD = 1; PCNextF = 32'h40; cycle();
        idle(); PCNextF = 32'h44; cycle();

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            rand_inputs();
            cycle();
        end

        idle();
        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
